// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared width and status-flag layout for the 16-bit adder ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int ALU_W  = 16;

    // Packed flag vector {S,ZR,CY,P,V} used by downstream flag consumers.
    localparam int FLAG_W  = 5;
    localparam int FLAG_S  = 4;
    localparam int FLAG_ZR = 3;
    localparam int FLAG_CY = 2;
    localparam int FLAG_P  = 1;
    localparam int FLAG_V  = 0;

    typedef struct packed {
        logic s;
        logic zr;
        logic cy;
        logic p;
        logic v;
    } flags_t;

    localparam flags_t c_FLAGS_RESET = '{s: 1'b0, zr: 1'b0, cy: 1'b0, p: 1'b0, v: 1'b0};

endpackage : alu_pkg
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// Module      : full_adder
// Description : One-bit gate-level full adder, the cell of the ripple chain.
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic w_axb;

    assign w_axb = a ^ b;
    assign s     = w_axb ^ cin;
    assign cout  = (a & b) | (cin & w_axb);

endmodule : full_adder
`default_nettype wire

// File: rtl/alu_16bit_struc.sv
`default_nettype none
// ============================================================================
// Module      : alu_16bit_struc
// Description : Structural ripple-carry adder ALU with registered sum and
//               sign/zero/carry/parity/overflow flags (1-cycle latency).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_16bit_struc
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ALU_W-1:0] X,
    input  logic [ALU_W-1:0] Y,
    output logic [ALU_W-1:0] Z,
    output logic             S,
    output logic             ZR,
    output logic             CY,
    output logic             P,
    output logic             V
);

    logic [ALU_W:0]   w_c;
    logic [ALU_W-1:0] w_sum;
    flags_t           w_flags;

    logic [ALU_W-1:0] r_z;
    flags_t           r_flags;

    assign w_c[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < ALU_W; gi++) begin : g_bit
            full_adder u_fa (
                .a    (X[gi]),
                .b    (Y[gi]),
                .cin  (w_c[gi]),
                .s    (w_sum[gi]),
                .cout (w_c[gi+1])
            );
        end
    endgenerate

    // Overflow uses the carry into vs. out of the sign bit.
    always_comb begin
        w_flags    = c_FLAGS_RESET;
        w_flags.s  = w_sum[ALU_W-1];
        w_flags.zr = (w_sum == '0);
        w_flags.cy = w_c[ALU_W];
        w_flags.p  = ~^w_sum;
        w_flags.v  = w_c[ALU_W-1] ^ w_c[ALU_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_z     <= '0;
            r_flags <= c_FLAGS_RESET;
        end else begin
            r_z     <= w_sum;
            r_flags <= w_flags;
        end
    end

    assign Z  = r_z;
    assign S  = r_flags.s;
    assign ZR = r_flags.zr;
    assign CY = r_flags.cy;
    assign P  = r_flags.p;
    assign V  = r_flags.v;

endmodule : alu_16bit_struc
`default_nettype wire

// File: tb/tb_alu_16bit_struc.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_16bit_struc
// Description : Self-checking bench for alu_16bit_struc against an arithmetic
//               reference model with directed and random operands.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_16bit_struc;

    logic        clk;
    logic        rst_n;
    logic [15:0] X;
    logic [15:0] Y;
    logic [15:0] Z;
    logic        S, ZR, CY, P, V;

    int checks;
    int errors;

    alu_16bit_struc dut (
        .clk   (clk),
        .rst_n (rst_n),
        .X     (X),
        .Y     (Y),
        .Z     (Z),
        .S     (S),
        .ZR    (ZR),
        .CY    (CY),
        .P     (P),
        .V     (V)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer addition, signed-range overflow, popcount parity.
    task automatic model(input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] z, output logic [4:0] f);
        int unsigned full;
        int sa, sb, ssum;
        full = int'(a) + int'(b);
        z    = full[15:0];
        sa   = a[15] ? int'(a) - 65536 : int'(a);
        sb   = b[15] ? int'(b) - 65536 : int'(b);
        ssum = sa + sb;
        f[4] = (z >= 16'h8000);
        f[3] = (z == 16'h0000);
        f[2] = (full > 65535);
        f[1] = ($countones(z) % 2 == 0);
        f[0] = (ssum > 32767) || (ssum < -32768);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        X = 16'hFFFF;
        Y = 16'h0001;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (Z !== 16'h0000 || {S, ZR, CY, P, V} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_hold: Z=%h flags=%b, required Z=0000 flags=00000", Z, {S, ZR, CY, P, V});
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (Z !== 16'h0000 || {S, ZR, CY, P, V} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_release_hold: Z=%h flags=%b, required Z=0000 flags=00000", Z, {S, ZR, CY, P, V});
        end
        @(posedge clk);
        #1;
        checks++;
        if (Z !== 16'h0000 || {S, ZR, CY, P, V} !== 5'b01110) begin
            errors++;
            $display("FAIL reset_first_load: Z=%h flags=%b, required Z=0000 flags=01110", Z, {S, ZR, CY, P, V});
        end
    endtask

    task automatic test_directed();
        logic [15:0] vx [4] = '{16'h8FFF, 16'hFFFE, 16'hAAAA, 16'h7FFF};
        logic [15:0] vy [4] = '{16'h8000, 16'h0002, 16'h5555, 16'h0001};
        logic [15:0] ez [4] = '{16'h0FFF, 16'h0000, 16'hFFFF, 16'h8000};
        logic [4:0]  ef [4] = '{5'b00111, 5'b01110, 5'b10010, 5'b10001};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            X = vx[i];
            Y = vy[i];
            @(posedge clk);
            #1;
            checks++;
            if (Z !== ez[i] || {S, ZR, CY, P, V} !== ef[i]) begin
                errors++;
                $display("FAIL directed_%0d: Z=%h flags=%b, required Z=%h flags=%b",
                         i, Z, {S, ZR, CY, P, V}, ez[i], ef[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] ez, a, b;
        logic [4:0]  ef;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            a = 16'($urandom);
            b = 16'($urandom);
            case (i % 6)
                0: b = 16'(-a);
                1: a = {1'b0, a[14:0]};
                2: b = 16'hFFFF;
                default: ;
            endcase
            X = a;
            Y = b;
            model(a, b, ez, ef);
            @(posedge clk);
            #1;
            checks++;
            if (Z !== ez || {S, ZR, CY, P, V} !== ef) begin
                errors++;
                $display("FAIL random_%0d X=%h Y=%h: Z=%h flags=%b, required Z=%h flags=%b",
                         i, a, b, Z, {S, ZR, CY, P, V}, ez, ef);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] vx [4] = '{16'h8FFF, 16'hFFFE, 16'hAAAA, 16'h7FFF};
        logic [15:0] vy [4] = '{16'h8000, 16'h0002, 16'h5555, 16'h0001};
        logic [15:0] ez, pz;
        logic [4:0]  ef, pf;
        @(posedge clk);
        #1;
        X = 16'h1234;
        Y = 16'h0001;
        @(posedge clk);
        model(16'h1234, 16'h0001, pz, pf);
        for (int i = 0; i < 4; i++) begin
            #1;
            X = vx[i];
            Y = vy[i];
            model(vx[i], vy[i], ez, ef);
            @(negedge clk);
            checks++;
            if (Z !== pz || {S, ZR, CY, P, V} !== pf) begin
                errors++;
                $display("FAIL b2b_hold_%0d: Z=%h flags=%b, required Z=%h flags=%b",
                         i, Z, {S, ZR, CY, P, V}, pz, pf);
            end
            @(posedge clk);
            #1;
            checks++;
            if (Z !== ez || {S, ZR, CY, P, V} !== ef) begin
                errors++;
                $display("FAIL b2b_load_%0d: Z=%h flags=%b, required Z=%h flags=%b",
                         i, Z, {S, ZR, CY, P, V}, ez, ef);
            end
            pz = ez;
            pf = ef;
            #(-1 + 1);
        end
        // Mid-stream reset between edges: outputs must clear without a clock.
        X = 16'h7FFF;
        Y = 16'h7FFF;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (Z !== 16'h0000 || {S, ZR, CY, P, V} !== 5'b00000) begin
            errors++;
            $display("FAIL async_reset: Z=%h flags=%b, required Z=0000 flags=00000", Z, {S, ZR, CY, P, V});
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (Z !== 16'h0000 || {S, ZR, CY, P, V} !== 5'b00000) begin
            errors++;
            $display("FAIL async_reset_hold: Z=%h flags=%b, required Z=0000 flags=00000", Z, {S, ZR, CY, P, V});
        end
        model(16'h7FFF, 16'h7FFF, ez, ef);
        @(posedge clk);
        #1;
        checks++;
        if (Z !== ez || {S, ZR, CY, P, V} !== ef) begin
            errors++;
            $display("FAIL async_reset_resume: Z=%h flags=%b, required Z=%h flags=%b",
                     Z, {S, ZR, CY, P, V}, ez, ef);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        X      = '0;
        Y      = '0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_alu_16bit_struc
`default_nettype wire
